// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - field-set input and instruction-word output bundle of the encoder
interface instr_encoder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // field-set input side
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [6:0]            funct7_i;
  logic [4:0]            vs2_i;
  logic [4:0]            vs1_i;
  logic [2:0]            funct3_i;
  logic [4:0]            vd_i;
  logic [6:0]            opcode_i;

  // instruction-word output side and status
  logic                  instr_valid_o;
  logic                  instr_ready_i;
  logic [DATA_WIDTH-1:0] instr_o;
  logic [CW-1:0]         count_o;
  logic [15:0]           issued_o;
  logic                  err_o;

  modport slave (
    input  in_valid_i, funct7_i, vs2_i, vs1_i, funct3_i, vd_i, opcode_i, instr_ready_i,
    output in_ready_o, instr_valid_o, instr_o, count_o, issued_o, err_o
  );

  modport master (
    output in_valid_i, funct7_i, vs2_i, vs1_i, funct3_i, vd_i, opcode_i, instr_ready_i,
    input  in_ready_o, instr_valid_o, instr_o, count_o, issued_o, err_o
  );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs R-type vector fields into instruction words and queues them for issue
module instr_encoder #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            rst_n,   // active-high despite the name
  instr_encoder_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // Only the architectural 32 bits are stored; upper word bits are always zero.
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [15:0]   r_issued;
  logic          r_err;

  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_accept;
  logic          w_legal;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_word;

  // Ready depends only on registered occupancy, so a pop cannot free a slot in the same cycle.
  assign w_in_ready  = (r_count < CW'(FIFO_DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_accept    = bus.in_valid_i && w_in_ready;
  assign w_legal     = (bus.opcode_i[1:0] == 2'b11);
  // Illegal opcodes complete the handshake but are never queued.
  assign w_push      = w_accept && w_legal;
  assign w_pop       = w_out_valid && bus.instr_ready_i;
  assign w_word      = {bus.funct7_i, bus.vs2_i, bus.vs1_i, bus.funct3_i, bus.vd_i, bus.opcode_i};

  assign bus.in_ready_o    = w_in_ready;
  assign bus.instr_valid_o = w_out_valid;
  assign bus.instr_o       = w_out_valid ? DATA_WIDTH'(r_mem[r_rptr]) : '0;
  assign bus.count_o       = r_count;
  assign bus.issued_o      = r_issued;
  assign bus.err_o         = r_err;

  // Storage array: written at the tail on every legal accept; contents are don't-care when not counted.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_word;
    end
  end

  // Pointers, occupancy, issue counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_issued <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr   <= r_rptr + AW'(1);
        r_issued <= r_issued + 16'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_accept && !w_legal) begin
        r_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized self-checking bench for instr_encoder
module tb_instr_encoder;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;

  instr_encoder_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

  instr_encoder #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests;
  int          n_fail;
  logic [31:0] exp_q[$];
  int unsigned exp_issued;
  bit          exp_err;

  function automatic logic [31:0] pack(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
                                       input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
    return (32'(f7) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'(op);
  endfunction

  function automatic logic [31:0] exp_head();
    return (exp_q.size() != 0) ? exp_q[0] : 32'h0;
  endfunction

  // Advance one clock and update the reference queue from what was presented before the edge.
  task automatic tick();
    bit          acc;
    bit          pop;
    bit          legal;
    logic [31:0] w;
    acc   = bus.in_valid_i && (exp_q.size() < DEPTH);
    pop   = (exp_q.size() != 0) && bus.instr_ready_i;
    legal = (bus.opcode_i[1:0] == 2'b11);
    w     = pack(bus.funct7_i, bus.vs2_i, bus.vs1_i, bus.funct3_i, bus.vd_i, bus.opcode_i);
    @(posedge clk);
    #1;
    if (rst_n) begin
      exp_q.delete();
      exp_issued = 0;
      exp_err    = 1'b0;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        exp_issued = (exp_issued + 1) % 65536;
      end
      if (acc) begin
        if (legal) exp_q.push_back(w);
        else       exp_err = 1'b1;
      end
    end
  endtask

  task automatic set_fields(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
                            input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
    bus.funct7_i = f7;
    bus.vs2_i    = s2;
    bus.vs1_i    = s1;
    bus.funct3_i = f3;
    bus.vd_i     = d;
    bus.opcode_i = op;
  endtask

  task automatic set_rand_legal();
    logic [31:0] r;
    r = $urandom;
    set_fields(r[6:0], r[11:7], r[16:12], r[19:17], r[24:20], {r[29:25], 2'b11});
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.in_valid_i = 1'b0;
    bus.instr_ready_i = 1'b0;
    set_fields(7'h0, 5'h0, 5'h0, 3'h0, 5'h0, 7'h0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    n_tests++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.count_o); end
    n_tests++; if (bus.instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.instr_valid_o); end
    n_tests++; if (bus.instr_o !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", bus.instr_o); end
    n_tests++; if (bus.issued_o !== 16'h0) begin n_fail++; $display("FAIL reset_issued: got %h expected 0", bus.issued_o); end
    n_tests++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err_o); end
    n_tests++; if (bus.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready_o); end
  endtask

  task automatic test_single();
    set_fields(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h57);
    bus.in_valid_i = 1'b1;
    bus.instr_ready_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    n_tests++; if (bus.instr_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", bus.instr_valid_o); end
    n_tests++; if (bus.instr_o !== 32'h002081D7) begin n_fail++; $display("FAIL single_word: got %h expected 002081d7", bus.instr_o); end
    n_tests++; if (bus.instr_o !== exp_head()) begin n_fail++; $display("FAIL single_model: got %h expected %h", bus.instr_o, exp_head()); end
    tick();
    n_tests++; if (bus.issued_o !== 16'd1) begin n_fail++; $display("FAIL single_issued: got %0d expected 1", bus.issued_o); end
    n_tests++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL single_count: got %0d expected 0", bus.count_o); end
  endtask

  task automatic test_fill();
    int unsigned issued0;
    issued0 = exp_issued;
    bus.instr_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_rand_legal();
      bus.in_valid_i = 1'b1;
      tick();
    end
    n_tests++; if (bus.count_o !== 3'(DEPTH)) begin n_fail++; $display("FAIL fill_count: got %0d expected %0d", bus.count_o, DEPTH); end
    n_tests++; if (bus.in_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready: got %b expected 0", bus.in_ready_o); end
    set_rand_legal();
    tick();
    bus.in_valid_i = 1'b0;
    n_tests++; if (bus.count_o !== 3'(DEPTH)) begin n_fail++; $display("FAIL fill_overflow_count: got %0d expected %0d", bus.count_o, DEPTH); end
    bus.instr_ready_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      n_tests++; if (bus.instr_o !== exp_head()) begin n_fail++; $display("FAIL fill_drain_order[%0d]: got %h expected %h", i, bus.instr_o, exp_head()); end
      tick();
    end
    n_tests++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL fill_drained: got %0d expected 0", bus.count_o); end
    n_tests++; if (bus.issued_o !== 16'(issued0 + 4)) begin n_fail++; $display("FAIL fill_issued: got %0d expected %0d", bus.issued_o, issued0 + 4); end
  endtask

  task automatic test_concurrent();
    bus.instr_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_rand_legal();
      bus.in_valid_i = 1'b1;
      tick();
    end
    n_tests++; if (bus.count_o !== 3'd2) begin n_fail++; $display("FAIL conc_prefill: got %0d expected 2", bus.count_o); end
    bus.instr_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_rand_legal();
      bus.in_valid_i = 1'b1;
      n_tests++; if (bus.instr_o !== exp_head()) begin n_fail++; $display("FAIL conc_order[%0d]: got %h expected %h", i, bus.instr_o, exp_head()); end
      tick();
      n_tests++; if (bus.count_o !== 3'd2) begin n_fail++; $display("FAIL conc_count[%0d]: got %0d expected 2", i, bus.count_o); end
    end
    bus.in_valid_i = 1'b0;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) begin
      n_tests++; if (bus.instr_o !== exp_head()) begin n_fail++; $display("FAIL conc_tail[%0d]: got %h expected %h", i, bus.instr_o, exp_head()); end
      tick();
    end
    n_tests++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL conc_drained: got %0d expected 0", bus.count_o); end
  endtask

  task automatic test_illegal();
    logic [31:0] r;
    bus.instr_ready_i = 1'b0;
    n_tests++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL illegal_pre_err: got %b expected 0", bus.err_o); end
    set_rand_legal();
    bus.in_valid_i = 1'b1;
    tick();
    r = $urandom;
    set_fields(r[6:0], r[11:7], r[16:12], r[19:17], r[24:20], 7'h54);
    tick();
    n_tests++; if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL illegal_err: got %b expected 1", bus.err_o); end
    set_rand_legal();
    tick();
    bus.in_valid_i = 1'b0;
    n_tests++; if (bus.count_o !== 3'd2) begin n_fail++; $display("FAIL illegal_count: got %0d expected 2", bus.count_o); end
    bus.instr_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_tests++; if (bus.instr_o !== exp_head()) begin n_fail++; $display("FAIL illegal_order[%0d]: got %h expected %h", i, bus.instr_o, exp_head()); end
      tick();
    end
    n_tests++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL illegal_drained: got %0d expected 0", bus.count_o); end
    n_tests++; if (bus.err_o !== exp_err) begin n_fail++; $display("FAIL illegal_sticky: got %b expected %b", bus.err_o, exp_err); end
  endtask

  task automatic test_reset_mid();
    bus.instr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_rand_legal();
      bus.in_valid_i = 1'b1;
      tick();
    end
    n_tests++; if (bus.count_o !== 3'd3 || bus.err_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got count=%0d err=%b expected count=3 err=1", bus.count_o, bus.err_o); end
    set_rand_legal();
    bus.instr_ready_i = 1'b1;
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.instr_ready_i = 1'b0;
    n_tests++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 0", bus.count_o); end
    n_tests++; if (bus.instr_valid_o !== 1'b0 || bus.instr_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_out: got valid=%b instr=%h expected 0/0", bus.instr_valid_o, bus.instr_o); end
    n_tests++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_err: got %b expected 0", bus.err_o); end
    n_tests++; if (bus.issued_o !== 16'h0) begin n_fail++; $display("FAIL rstmid_issued: got %h expected 0", bus.issued_o); end
    tick();
    n_tests++; if (bus.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b expected 1", bus.in_ready_o); end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int          bad;
    bus.instr_ready_i = 1'b0;
    set_rand_legal();
    bus.in_valid_i = 1'b1;
    tick();
    held = exp_head();
    for (int i = 0; i < 5; i++) begin
      set_rand_legal();
      tick();
      n_tests++; if (bus.instr_o !== held || bus.instr_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h/%b expected %h/1", i, bus.instr_o, bus.instr_valid_o, held); end
    end
    n_tests++; if (bus.count_o !== 3'(DEPTH)) begin n_fail++; $display("FAIL bp_full: got %0d expected %0d", bus.count_o, DEPTH); end
    bus.instr_ready_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 70000 && exp_issued != 65535; i++) begin
      set_rand_legal();
      tick();
      if (bus.issued_o !== 16'(exp_issued) || bus.instr_o !== exp_head()) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL bp_stream: got %0d bad cycles expected 0", bad); end
    n_tests++; if (bus.issued_o !== 16'hFFFF) begin n_fail++; $display("FAIL bp_preload: got %h expected ffff", bus.issued_o); end
    bus.in_valid_i = 1'b0;
    tick();
    n_tests++; if (bus.issued_o !== 16'h0000) begin n_fail++; $display("FAIL bp_wrap: got %h expected 0000", bus.issued_o); end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    exp_issued = 0;
    exp_err    = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_concurrent();
    test_illegal();
    test_reset_mid();
    test_backpressure();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
